// File: rtl/pc_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_seq
// Purpose  : Fetch-side PC sequencer placed directly in front of the valid/PC
//            pipeline. Every enabled cycle it produces the issue valid (pc_en)
//            and the issue PC (pc0). It takes redirects from the early
//            unconditional-branch stage (br) and from the late
//            conditional-resolve stage (br_c), inserts a configurable number
//            of redirect bubbles, and supports halt/resume. It runs on the
//            same global enable as the pipeline, so both stall together.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1         rising-edge clock
//   r          in   1         synchronous active-high reset
//   en         in   1         global pipeline advance enable
//   halt       in   1         level-sensitive stop-issue request
//   br         in   1         unconditional-branch redirect (younger)
//   br_tgt     in   PC_WIDTH  target for br
//   br_c       in   1         conditional-branch redirect (older)
//   br_c_tgt   in   PC_WIDTH  target for br_c
//   pc_en      out  1         issue valid, registered
//   pc0        out  PC_WIDTH  issue PC, registered
//   busy_redir out  1         in REDIR state or a redirect is pending
// ============================================================================
module pc_fetch_seq #(
  parameter int unsigned         PC_WIDTH      = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC      = '0,
  parameter logic [PC_WIDTH-1:0] PC_INC        = PC_WIDTH'(4),
  parameter int unsigned         REDIR_BUBBLES = 1
) (
  input  logic                clk,
  input  logic                r,
  input  logic                en,
  input  logic                halt,
  input  logic                br,
  input  logic [PC_WIDTH-1:0] br_tgt,
  input  logic                br_c,
  input  logic [PC_WIDTH-1:0] br_c_tgt,
  output logic                pc_en,
  output logic [PC_WIDTH-1:0] pc0,
  output logic                busy_redir
);

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_RUN    = 2'd1,
    ST_REDIR  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  // The cycle right after a redirect is already the first bubble, so the
  // counter is loaded with the number of additional bubbles still owed.
  localparam logic       C_HAS_BUBBLES = (REDIR_BUBBLES != 0);
  localparam logic [2:0] C_BUB_RELOAD  =
      (REDIR_BUBBLES == 0) ? 3'd0 : 3'(REDIR_BUBBLES - 1);

  state_t                state_q,    state_d;
  logic                  pc_en_q,    pc_en_d;
  logic [PC_WIDTH-1:0]   pc0_q,      pc0_d;
  logic [2:0]            bub_cnt_q,  bub_cnt_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [PC_WIDTH-1:0]   pend_tgt_q, pend_tgt_d;
  logic                  pend_c_q,   pend_c_d;

  // --------------------------------------------------------------------------
  // Redirect arbitration.
  // A live br_c always wins. A live br replaces the pending slot unless the
  // slot holds a br_c: the br_c belongs to an older instruction and the br
  // came from the wrong path that br_c is about to squash.
  // --------------------------------------------------------------------------
  logic                w_live_vld;
  logic                w_live_c;
  logic [PC_WIDTH-1:0] w_live_tgt;
  logic                w_take_live;
  logic                w_m_vld;
  logic                w_m_c;
  logic [PC_WIDTH-1:0] w_m_tgt;

  assign w_live_vld  = br | br_c;
  assign w_live_c    = br_c;
  assign w_live_tgt  = br_c ? br_c_tgt : br_tgt;
  assign w_take_live = w_live_vld & ~(pend_vld_q & pend_c_q & ~w_live_c);
  assign w_m_vld     = w_live_vld | pend_vld_q;
  assign w_m_c       = w_take_live ? w_live_c   : pend_c_q;
  assign w_m_tgt     = w_take_live ? w_live_tgt : pend_tgt_q;

  // --------------------------------------------------------------------------
  // Next-state / next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pc_en_d    = pc_en_q;
    pc0_d      = pc0_q;
    bub_cnt_d  = bub_cnt_q;
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;
    pend_c_d   = pend_c_q;

    if (!en) begin
      // Stalled: only the pending slot may change.
      if (w_live_vld) begin
        pend_vld_d = 1'b1;
        pend_tgt_d = w_m_tgt;
        pend_c_d   = w_m_c;
      end
    end else begin
      // Any pending redirect is consumed on this enabled cycle.
      pend_vld_d = 1'b0;
      pend_c_d   = 1'b0;

      if (w_m_vld) begin
        pc0_d   = w_m_tgt;
        pc_en_d = 1'b0;
        if (state_q == ST_HALTED) begin
          // Retarget only; resume happens when halt drops.
          state_d = ST_HALTED;
        end else if (C_HAS_BUBBLES) begin
          // Halt, if still asserted, is honoured once the bubbles finish.
          state_d   = ST_REDIR;
          bub_cnt_d = C_BUB_RELOAD;
        end else if (halt) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_RUN;
          pc_en_d = 1'b1;
        end
      end else begin
        case (state_q)
          ST_START: begin
            if (halt) begin
              state_d = ST_HALTED;
              pc_en_d = 1'b0;
            end else begin
              state_d = ST_RUN;
              pc_en_d = 1'b1;
            end
          end

          ST_RUN: begin
            // pc0 advances to the next un-issued PC whether or not we halt.
            pc0_d = pc0_q + PC_INC;
            if (halt) begin
              state_d = ST_HALTED;
              pc_en_d = 1'b0;
            end else begin
              pc_en_d = 1'b1;
            end
          end

          ST_REDIR: begin
            if (bub_cnt_q == 3'd0) begin
              if (halt) begin
                state_d = ST_HALTED;
                pc_en_d = 1'b0;
              end else begin
                state_d = ST_RUN;
                pc_en_d = 1'b1;
              end
            end else begin
              bub_cnt_d = bub_cnt_q - 3'd1;
              pc_en_d   = 1'b0;
            end
          end

          ST_HALTED: begin
            pc_en_d = 1'b0;
            if (!halt) begin
              state_d = ST_RUN;
              pc_en_d = 1'b1;
            end
          end

          default: begin
            state_d = ST_START;
            pc_en_d = 1'b0;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (r) begin
      state_q    <= ST_START;
      pc_en_q    <= 1'b0;
      pc0_q      <= RESET_PC;
      bub_cnt_q  <= 3'd0;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= '0;
      pend_c_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_en_q    <= pc_en_d;
      pc0_q      <= pc0_d;
      bub_cnt_q  <= bub_cnt_d;
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
      pend_c_q   <= pend_c_d;
    end
  end

  assign pc_en      = pc_en_q;
  assign pc0        = pc0_q;
  assign busy_redir = (state_q == ST_REDIR) | pend_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_seq
// Purpose  : Self-checking bench for pc_fetch_seq. Two instances share the
//            stimulus: dut_a (32-bit, RESET_PC=0x100, one bubble) and dut_b
//            (8-bit, RESET_PC=0xF4, two bubbles). Each vector names the
//            instance it checks; expected outputs are queued as the stimulus
//            is driven and popped after the clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_seq;

  logic        clk = 1'b0;
  logic        r = 1'b1;
  logic        en = 1'b0;
  logic        halt = 1'b0;
  logic        br = 1'b0;
  logic [31:0] br_tgt = '0;
  logic        br_c = 1'b0;
  logic [31:0] br_c_tgt = '0;

  logic        pc_en_a, busy_a;
  logic [31:0] pc0_a;
  logic        pc_en_b, busy_b;
  logic [7:0]  pc0_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch_seq #(
    .PC_WIDTH(32), .RESET_PC(32'h100), .PC_INC(32'd4), .REDIR_BUBBLES(1)
  ) dut_a (
    .clk(clk), .r(r), .en(en), .halt(halt),
    .br(br), .br_tgt(br_tgt), .br_c(br_c), .br_c_tgt(br_c_tgt),
    .pc_en(pc_en_a), .pc0(pc0_a), .busy_redir(busy_a)
  );

  pc_fetch_seq #(
    .PC_WIDTH(8), .RESET_PC(8'hF4), .PC_INC(8'd4), .REDIR_BUBBLES(2)
  ) dut_b (
    .clk(clk), .r(r), .en(en), .halt(halt),
    .br(br), .br_tgt(br_tgt[7:0]), .br_c(br_c), .br_c_tgt(br_c_tgt[7:0]),
    .pc_en(pc_en_b), .pc0(pc0_b), .busy_redir(busy_b)
  );

  typedef struct {
    bit          sel;   // 0: dut_a, 1: dut_b
    bit          r, en, halt, br;
    logic [31:0] bt;
    bit          brc;
    logic [31:0] ct;
    bit          pe;
    logic [31:0] pc;
    bit          busy;
  } vec_t;

  vec_t exp_q[$];

  function automatic vec_t mk(bit sel, bit rr, bit e, bit h, bit b,
                              logic [31:0] bt, bit bc, logic [31:0] ct,
                              bit pe, logic [31:0] pc, bit busy);
    vec_t v;
    v.sel = sel; v.r = rr; v.en = e; v.halt = h; v.br = b; v.bt = bt;
    v.brc = bc; v.ct = ct; v.pe = pe; v.pc = pc; v.busy = busy;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    r = v.r; en = v.en; halt = v.halt;
    br = v.br; br_tgt = v.bt; br_c = v.brc; br_c_tgt = v.ct;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    vec_t sv[$];
    vec_t e;
    sv.push_back(mk(0, 1,1,0,1,32'h400,1,32'h800, 0,32'h100,0));
    sv.push_back(mk(1, 1,1,1,0,32'h0,  0,32'h0,   0,32'hF4, 0));
    sv.push_back(mk(0, 1,0,0,0,32'h0,  0,32'h0,   0,32'h100,0));
    foreach (sv[i]) begin
      drive(sv[i]); exp_q.push_back(sv[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks += 3;
      if ((e.sel ? pc_en_b : pc_en_a) !== e.pe) begin errors++;
        $display("FAIL reset[%0d] pc_en got %b want %b", i, e.sel ? pc_en_b : pc_en_a, e.pe); end
      if ((e.sel ? {24'h0, pc0_b} : pc0_a) !== e.pc) begin errors++;
        $display("FAIL reset[%0d] pc0 got %h want %h", i, e.sel ? {24'h0, pc0_b} : pc0_a, e.pc); end
      if ((e.sel ? busy_b : busy_a) !== e.busy) begin errors++;
        $display("FAIL reset[%0d] busy got %b want %b", i, e.sel ? busy_b : busy_a, e.busy); end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_sequential();
    vec_t sv[$];
    vec_t e;
    sv.push_back(mk(0, 0,1,0,0,0,0,0, 1,32'h100,0));
    sv.push_back(mk(0, 0,1,0,0,0,0,0, 1,32'h104,0));
    sv.push_back(mk(0, 0,1,0,0,0,0,0, 1,32'h108,0));
    foreach (sv[i]) begin
      drive(sv[i]); exp_q.push_back(sv[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks += 3;
      if (pc_en_a !== e.pe) begin errors++;
        $display("FAIL seq[%0d] pc_en got %b want %b", i, pc_en_a, e.pe); end
      if (pc0_a !== e.pc) begin errors++;
        $display("FAIL seq[%0d] pc0 got %h want %h", i, pc0_a, e.pc); end
      if (busy_a !== e.busy) begin errors++;
        $display("FAIL seq[%0d] busy got %b want %b", i, busy_a, e.busy); end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Single br, then br and br_c together (br_c must win).
  task automatic test_branch();
    vec_t sv[$];
    vec_t e;
    sv.push_back(mk(0, 0,1,0,1,32'h400,0,32'h0,   0,32'h400,1));
    sv.push_back(mk(0, 0,1,0,0,32'h0,  0,32'h0,   1,32'h400,0));
    sv.push_back(mk(0, 0,1,0,0,32'h0,  0,32'h0,   1,32'h404,0));
    sv.push_back(mk(0, 0,0,0,0,32'h0,  0,32'h0,   1,32'h404,0));
    sv.push_back(mk(0, 0,1,0,1,32'h400,1,32'h800, 0,32'h800,1));
    sv.push_back(mk(0, 0,1,0,0,32'h0,  0,32'h0,   1,32'h800,0));
    sv.push_back(mk(0, 0,1,0,0,32'h0,  0,32'h0,   1,32'h804,0));
    foreach (sv[i]) begin
      drive(sv[i]); exp_q.push_back(sv[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks += 3;
      if (pc_en_a !== e.pe) begin errors++;
        $display("FAIL branch[%0d] pc_en got %b want %b", i, pc_en_a, e.pe); end
      if (pc0_a !== e.pc) begin errors++;
        $display("FAIL branch[%0d] pc0 got %h want %h", i, pc0_a, e.pc); end
      if (busy_a !== e.busy) begin errors++;
        $display("FAIL branch[%0d] busy got %b want %b", i, busy_a, e.busy); end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Redirects captured during a stall, plus live br_c beating a pending br.
  task automatic test_pending();
    vec_t sv[$];
    vec_t e;
    sv.push_back(mk(0, 0,0,0,1,32'h200,0,32'h0,   1,32'h804,1));
    sv.push_back(mk(0, 0,0,0,0,32'h0,  1,32'h300, 1,32'h804,1));
    sv.push_back(mk(0, 0,0,0,1,32'h500,0,32'h0,   1,32'h804,1));
    sv.push_back(mk(0, 0,1,0,0,32'h0,  0,32'h0,   0,32'h300,1));
    sv.push_back(mk(0, 0,1,0,0,32'h0,  0,32'h0,   1,32'h300,0));
    sv.push_back(mk(0, 0,1,0,0,32'h0,  0,32'h0,   1,32'h304,0));
    sv.push_back(mk(0, 0,0,0,1,32'h600,0,32'h0,   1,32'h304,1));
    sv.push_back(mk(0, 0,1,0,0,32'h0,  1,32'h700, 0,32'h700,1));
    sv.push_back(mk(0, 0,1,0,0,32'h0,  0,32'h0,   1,32'h700,0));
    foreach (sv[i]) begin
      drive(sv[i]); exp_q.push_back(sv[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks += 3;
      if (pc_en_a !== e.pe) begin errors++;
        $display("FAIL pending[%0d] pc_en got %b want %b", i, pc_en_a, e.pe); end
      if (pc0_a !== e.pc) begin errors++;
        $display("FAIL pending[%0d] pc0 got %h want %h", i, pc0_a, e.pc); end
      if (busy_a !== e.busy) begin errors++;
        $display("FAIL pending[%0d] busy got %b want %b", i, busy_a, e.busy); end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Halt in RUN, retarget while halted, release without bubble; halt during
  // REDIR; pending redirect applied while halted; redirect+halt same cycle.
  task automatic test_halt();
    vec_t sv[$];
    vec_t e;
    sv.push_back(mk(0, 0,1,0,1,32'h104,0,32'h0,   0,32'h104,1));
    sv.push_back(mk(0, 0,1,0,0,32'h0,  0,32'h0,   1,32'h104,0));
    sv.push_back(mk(0, 0,1,0,0,32'h0,  0,32'h0,   1,32'h108,0));
    sv.push_back(mk(0, 0,1,0,0,32'h0,  0,32'h0,   1,32'h10C,0));
    sv.push_back(mk(0, 0,1,1,0,32'h0,  0,32'h0,   0,32'h110,0));
    sv.push_back(mk(0, 0,1,1,0,32'h0,  1,32'h900, 0,32'h900,0));
    sv.push_back(mk(0, 0,1,1,0,32'h0,  0,32'h0,   0,32'h900,0));
    sv.push_back(mk(0, 0,1,0,0,32'h0,  0,32'h0,   1,32'h900,0));
    sv.push_back(mk(0, 0,1,0,0,32'h0,  0,32'h0,   1,32'h904,0));
    sv.push_back(mk(0, 0,1,0,1,32'hA00,0,32'h0,   0,32'hA00,1));
    sv.push_back(mk(0, 0,1,1,0,32'h0,  0,32'h0,   0,32'hA00,0));
    sv.push_back(mk(0, 0,0,1,1,32'hB00,0,32'h0,   0,32'hA00,1));
    sv.push_back(mk(0, 0,1,1,0,32'h0,  0,32'h0,   0,32'hB00,0));
    sv.push_back(mk(0, 0,1,0,0,32'h0,  0,32'h0,   1,32'hB00,0));
    sv.push_back(mk(0, 0,1,1,1,32'hC00,0,32'h0,   0,32'hC00,1));
    sv.push_back(mk(0, 0,1,1,0,32'h0,  0,32'h0,   0,32'hC00,0));
    sv.push_back(mk(0, 0,1,0,0,32'h0,  0,32'h0,   1,32'hC00,0));
    sv.push_back(mk(0, 0,1,0,0,32'h0,  0,32'h0,   1,32'hC04,0));
    foreach (sv[i]) begin
      drive(sv[i]); exp_q.push_back(sv[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks += 3;
      if (pc_en_a !== e.pe) begin errors++;
        $display("FAIL halt[%0d] pc_en got %b want %b", i, pc_en_a, e.pe); end
      if (pc0_a !== e.pc) begin errors++;
        $display("FAIL halt[%0d] pc0 got %h want %h", i, pc0_a, e.pc); end
      if (busy_a !== e.busy) begin errors++;
        $display("FAIL halt[%0d] busy got %b want %b", i, busy_a, e.busy); end
    end
  endtask

  // ---------------------------------------------------------------------------
  // 8-bit instance: wrap, two-bubble redirect, reset mid-REDIR with pending.
  task automatic test_wrap_reset();
    vec_t sv[$];
    vec_t e;
    sv.push_back(mk(1, 1,1,0,0,32'h0, 0,32'h0,  0,32'hF4,0));
    sv.push_back(mk(1, 0,1,0,0,32'h0, 0,32'h0,  1,32'hF4,0));
    sv.push_back(mk(1, 0,1,0,0,32'h0, 0,32'h0,  1,32'hF8,0));
    sv.push_back(mk(1, 0,1,0,0,32'h0, 0,32'h0,  1,32'hFC,0));
    sv.push_back(mk(1, 0,1,0,0,32'h0, 0,32'h0,  1,32'h00,0));
    sv.push_back(mk(1, 0,1,0,0,32'h0, 0,32'h0,  1,32'h04,0));
    sv.push_back(mk(1, 0,1,0,1,32'h40,0,32'h0,  0,32'h40,1));
    sv.push_back(mk(1, 0,1,0,0,32'h0, 0,32'h0,  0,32'h40,1));
    sv.push_back(mk(1, 0,1,0,0,32'h0, 0,32'h0,  1,32'h40,0));
    sv.push_back(mk(1, 0,1,0,0,32'h0, 0,32'h0,  1,32'h44,0));
    sv.push_back(mk(1, 0,1,0,1,32'h80,0,32'h0,  0,32'h80,1));
    sv.push_back(mk(1, 0,0,0,0,32'h0, 1,32'h90, 0,32'h80,1));
    sv.push_back(mk(1, 1,1,0,0,32'h0, 0,32'h0,  0,32'hF4,0));
    sv.push_back(mk(1, 0,0,0,0,32'h0, 0,32'h0,  0,32'hF4,0));
    sv.push_back(mk(1, 0,1,0,0,32'h0, 0,32'h0,  1,32'hF4,0));
    foreach (sv[i]) begin
      drive(sv[i]); exp_q.push_back(sv[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks += 3;
      if (pc_en_b !== e.pe) begin errors++;
        $display("FAIL wrap[%0d] pc_en got %b want %b", i, pc_en_b, e.pe); end
      if ({24'h0, pc0_b} !== e.pc) begin errors++;
        $display("FAIL wrap[%0d] pc0 got %h want %h", i, pc0_b, e.pc[7:0]); end
      if (busy_b !== e.busy) begin errors++;
        $display("FAIL wrap[%0d] busy got %b want %b", i, busy_b, e.busy); end
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_sequential();
    test_branch();
    test_pending();
    test_halt();
    test_wrap_reset();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_fetch_seq.md
Name: pc_fetch_seq

Overview:
Fetch-side PC sequencer that sits directly upstream of the valid/PC pipeline. It generates the issue valid (pc_en) and issue PC (pc0) every enabled cycle. It absorbs redirects from the unconditional-branch stage (br) and the conditional-resolve stage (br_c), inserts configurable redirect bubbles, and supports halt/resume. It shares the pipeline's global enable (en), so the sequencer and the pipeline stall in lockstep.

Parameters:
PC_WIDTH, 32, width of PC and branch targets
RESET_PC, 0, first PC issued after reset
PC_INC, 4, sequential PC increment
REDIR_BUBBLES, 1, number of pc_en=0 cycles inserted after a redirect (0..7)

Ports:
clk  input  1  single clock, rising edge
r  input  1  synchronous reset, active-high
en  input  1  global pipeline advance enable (same signal the valid pipeline uses)
halt  input  1  request to stop issuing; level-sensitive
br  input  1  unconditional-branch redirect, resolved early
br_tgt  input  PC_WIDTH  target for br
br_c  input  1  conditional-branch redirect, resolved late (older instruction)
br_c_tgt  input  PC_WIDTH  target for br_c
pc_en  output  1  issue valid, registered
pc0  output  PC_WIDTH  issue PC, registered
busy_redir  output  1  high while in REDIR state or while a redirect is pending

Behaviour:
- Interface: one clock, clk. Reset r is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: pc_en=0, pc0=RESET_PC, busy_redir=0, state=START, pending redirect cleared, bubble counter=0. Reset overrides en and all other inputs.
- FSM states: START, RUN, REDIR, HALTED. No state or register changes while en=0, except pending-redirect capture.
- START: on the first en=1 cycle, move to RUN with pc_en=1 and pc0=RESET_PC (one-cycle post-reset gap).
- RUN, en=1, no event: pc_en=1, pc0 <= pc0+PC_INC (wraps modulo 2^PC_WIDTH).
- Redirect (en=1, br or br_c): pc0 <= target and pc_en <= 0.
  - If REDIR_BUBBLES=0: pc_en=1 on the next cycle instead.
  - Otherwise go to REDIR and hold pc_en=0 for exactly REDIR_BUBBLES enabled cycles. Then go to RUN with pc_en=1 and pc0=target; increment resumes on the following cycle.
- Simultaneous br and br_c: br_c wins (older instruction); br is discarded.
- Redirect while in REDIR: restart the bubble count with the new target. A br arriving after an in-flight br_c redirect is applied (it belongs to the new path).
- Redirect while en=0: latch into a pending slot (valid, target, is_c).
  - A later br_c overwrites a pending br.
  - A later br does not overwrite a pending br_c.
  - On the next en=1 cycle the pending redirect is applied exactly as if it arrived then. A same-cycle live br_c beats a pending br.
  - busy_redir=1 while pending.
- halt, en=1, in RUN: next cycle pc_en=0 and pc0 holds the next un-issued PC; state=HALTED.
- HALTED: pc_en stays 0. A redirect updates pc0 and remains HALTED with no bubble count. When halt deasserts, the next enabled cycle gives pc_en=1 with the held pc0, state=RUN.
- Redirect has priority over halt in the same cycle: the target is loaded, then halt applies.
- halt during REDIR: the bubbles complete, then the block enters HALTED instead of RUN.
- Reset mid-operation (any state, pending slot full): everything returns to reset values on the next edge; pending redirect is lost.
- Outputs are fully registered; there is no combinational path from inputs to pc_en or pc0.

Test Plan:
- Reset then en=1 steady, RESET_PC=0x100 -> pc_en 0,1,1,1; pc0 0x100,0x100,0x104,0x108.
- RUN at pc0=0x108, pulse br with br_tgt=0x400, REDIR_BUBBLES=1 -> next cycle pc_en=0, then pc_en=1 with pc0=0x400, then 0x404.
- Same cycle br (tgt 0x400) and br_c (tgt 0x800) -> pc0=0x800 after bubble; 0x400 is never issued.
- en=0 for 3 cycles; pulse br (0x200), then br_c (0x300), then br (0x500) during the stall -> outputs frozen, busy_redir=1; after en=1 the first valid PC is 0x300.
- halt asserted at pc0=0x10C -> pc_en=0 with pc0 held at 0x110; br_c to 0x900 while halted; halt released -> pc_en=1 with pc0=0x900, no bubble.
- PC_WIDTH=8, pc0=0xFC, PC_INC=4 -> wraps to 0x00; assert r mid-REDIR with pending set -> pc_en=0, pc0=RESET_PC, busy_redir=0.
